// File: rtl/itr_ctrl.sv
// Interrupt controller for the floating-point core: edge-collects NSRC sources,
// masks them, and sequences a one-cycle itr pulse per lowest-index eligible source.
module itr_ctrl #(
    parameter int unsigned NSRC      = 4,
    parameter int unsigned NBDATA    = 23,
    parameter int unsigned NUIOIN    = 8,
    parameter int unsigned NUIOOU    = 8,
    parameter int unsigned MASK_ADDR = NUIOOU - 1,
    parameter int unsigned STAT_ADDR = NUIOIN - 1,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSRC-1:0]           irq,
    input  logic                      out_en,
    input  logic [$clog2(NUIOOU)-1:0] addr_out,
    input  logic [NBDATA-1:0]         data_out,
    input  logic                      req_in,
    input  logic [$clog2(NUIOIN)-1:0] addr_in,
    output logic [NBDATA-1:0]         io_data,
    output logic                      itr,
    output logic [$clog2(NSRC)-1:0]   itr_id,
    input  logic                      itr_end
);

    localparam int unsigned IDW = $clog2(NSRC);
    localparam int unsigned AWO = $clog2(NUIOOU);
    localparam int unsigned AWI = $clog2(NUIOIN);
    localparam int unsigned HW  = $clog2(HOLDOFF + 1);
    localparam logic [AWO-1:0] MASK_A = AWO'(MASK_ADDR);
    localparam logic [AWI-1:0] STAT_A = AWI'(STAT_ADDR);

    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [NSRC-1:0] mask, mask_nxt;
    logic [NSRC-1:0] pend, pend_nxt;
    logic [NSRC-1:0] irq_prev;
    logic [NSRC-1:0] rise, eligible, win_oh, pend_clr;
    logic [IDW-1:0]  winner, itr_id_nxt;
    logic [HW-1:0]   hold, hold_nxt;
    logic            itr_nxt;
    logic            busy;
    logic            unused_data;

    // Only the low NSRC bits of the output word carry the mask.
    assign unused_data = ^data_out[NBDATA-1:NSRC];

    assign rise     = irq & ~irq_prev;
    assign eligible = pend & mask;
    assign busy     = (state != IDLE);

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        winner = '0;
        win_oh = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner    = IDW'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        itr_nxt    = 1'b0;
        itr_id_nxt = itr_id;
        hold_nxt   = hold;
        pend_clr   = '0;
        mask_nxt   = mask;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    itr_id_nxt = winner;
                    pend_clr   = win_oh;
                    itr_nxt    = 1'b1;
                    state_nxt  = ASSERT;
                end
            end
            ASSERT:  state_nxt = SERVICE;
            SERVICE: begin
                if (itr_end) begin
                    hold_nxt  = HW'(HOLDOFF - 1);
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold == '0) state_nxt = IDLE;
                else            hold_nxt  = hold - HW'(1);
            end
            default: state_nxt = IDLE;
        endcase
        // A fresh rise on the granted source survives its own clear.
        pend_nxt = (pend & ~pend_clr) | rise;
        if (out_en && addr_out == MASK_A) mask_nxt = data_out[NSRC-1:0];
    end

    always_ff @(posedge clk) begin
        irq_prev <= irq;
        if (rst) begin
            state  <= IDLE;
            mask   <= '0;
            pend   <= '0;
            itr    <= 1'b0;
            itr_id <= '0;
            hold   <= '0;
        end else begin
            state  <= state_nxt;
            mask   <= mask_nxt;
            pend   <= pend_nxt;
            itr    <= itr_nxt;
            itr_id <= itr_id_nxt;
            hold   <= hold_nxt;
        end
    end

    // Status word, LSB first: pend, itr_id, busy.
    always_comb begin
        io_data = '0;
        if (req_in && addr_in == STAT_A) io_data = NBDATA'({busy, itr_id, pend});
    end

endmodule

// File: tb/tb_itr_ctrl.sv
// Directed bench for itr_ctrl: expected itr grants (id and cycle) are queued when
// stimulus is driven and checked by a monitor when itr fires.
module tb_itr_ctrl;

    localparam int unsigned NSRC    = 4;
    localparam int unsigned NBDATA  = 23;
    localparam int unsigned NUIOIN  = 8;
    localparam int unsigned NUIOOU  = 8;
    localparam int unsigned HOLDOFF = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NSRC-1:0]           irq;
    logic                      out_en;
    logic [$clog2(NUIOOU)-1:0] addr_out;
    logic [NBDATA-1:0]         data_out;
    logic                      req_in;
    logic [$clog2(NUIOIN)-1:0] addr_in;
    logic [NBDATA-1:0]         io_data;
    logic                      itr;
    logic [$clog2(NSRC)-1:0]   itr_id;
    logic                      itr_end;

    itr_ctrl #(
        .NSRC(NSRC), .NBDATA(NBDATA), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU),
        .MASK_ADDR(NUIOOU - 1), .STAT_ADDR(NUIOIN - 1), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq), .out_en(out_en), .addr_out(addr_out),
        .data_out(data_out), .req_in(req_in), .addr_in(addr_in), .io_data(io_data),
        .itr(itr), .itr_id(itr_id), .itr_end(itr_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic itr_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every itr pulse must match the oldest expected grant.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (itr_q) check("itr_one_cycle", 32'(itr), 32'd0);
        if (itr === 1'b1) begin
            if (sb.size() == 0) begin
                check("itr_unexpected", 32'(itr), 32'd0);
            end else begin
                e = sb.pop_front();
                check("itr_id_grant", 32'(itr_id), 32'(e.id));
                check("itr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        itr_q = itr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input int addr, input logic [NSRC-1:0] v);
        out_en   = 1'b1;
        addr_out = 3'(addr);
        data_out = {(NBDATA - NSRC)'($urandom), v};
        step();
        out_en   = 1'b0;
    endtask

    task automatic rd_stat(input string tag, input logic [31:0] exp);
        req_in  = 1'b1;
        addr_in = 3'(NUIOIN - 1);
        #1;
        check(tag, 32'(io_data), exp);
        req_in  = 1'b0;
    endtask

    task automatic fire(input logic [NSRC-1:0] bits, input int id);
        irq = bits;
        sb.push_back('{id, cyc + 2});
        step();
        irq = '0;
    endtask

    // End of service; the next grant lands after the consuming edge, HOLDOFF hold
    // cycles, and one IDLE decision edge.
    task automatic end_svc(input int next_id);
        if (next_id >= 0) sb.push_back('{next_id, cyc + HOLDOFF + 2});
        itr_end = 1'b1;
        step();
        itr_end = 1'b0;
        repeat (HOLDOFF + 4) step();
    endtask

    initial begin
        rst = 1'b1; irq = '0; out_en = 1'b0; addr_out = '0; data_out = '0;
        req_in = 1'b0; addr_in = '0; itr_end = 1'b0;
        repeat (3) step();
        check("rst_itr", 32'(itr), 32'd0);
        check("rst_itr_id", 32'(itr_id), 32'd0);
        rd_stat("rst_stat", 32'h0);
        req_in = 1'b1; addr_in = 3'd3; #1;
        check("other_addr_read", 32'(io_data), 32'h0);
        req_in = 1'b0;
        rst = 1'b0;
        step();

        // Single source, 2-cycle latency, status while busy
        wr(NUIOOU - 1, 4'b0101);
        fire(4'b0100, 2);
        step();
        check("t1_itr", 32'(itr), 32'd1);
        check("t1_id", 32'(itr_id), 32'd2);
        rd_stat("t1_stat", 32'h60);
        step();
        check("t1_itr_low", 32'(itr), 32'd0);
        end_svc(-1);

        // Simultaneous rises: lowest index first, then the other after hold
        wr(NUIOOU - 1, 4'b1111);
        fire(4'b1010, 1);
        step();
        rd_stat("t2_stat", 32'h58);
        step();
        end_svc(3);
        rd_stat("t2_stat3", 32'h70);
        end_svc(-1);

        // Masked source stays pending; unmasking grants it
        wr(NUIOOU - 1, 4'b0000);
        irq = 4'b0001;
        step();
        irq = '0;
        repeat (3) step();
        check("t3_no_itr", 32'(itr), 32'd0);
        rd_stat("t3_stat", 32'h31);
        wr(NUIOOU - 2, 4'b1111);
        repeat (2) step();
        rd_stat("t3_stat_other_addr", 32'h31);
        out_en = 1'b1; addr_out = 3'(NUIOOU - 1); data_out = 23'h1;
        sb.push_back('{0, cyc + 2});
        step();
        out_en = 1'b0;
        step();
        check("t3_itr", 32'(itr), 32'd1);
        rd_stat("t3_stat_busy", 32'h40);
        step();
        end_svc(-1);

        // Re-rise of the in-service source waits for hold to expire
        wr(NUIOOU - 1, 4'b0100);
        fire(4'b0100, 2);
        repeat (2) step();
        irq = 4'b0100;
        step();
        irq = '0;
        check("t4_no_nest", 32'(itr), 32'd0);
        rd_stat("t4_stat", 32'h64);
        end_svc(2);
        rd_stat("t4_stat2", 32'h60);
        end_svc(-1);

        // Line high through reset release makes no edge; stray itr_end ignored
        irq = 4'b0010;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        wr(NUIOOU - 1, 4'b0010);
        repeat (3) step();
        rd_stat("t5_stat", 32'h0);
        itr_end = 1'b1;
        step();
        itr_end = 1'b0;
        rd_stat("t5_stat_after_end", 32'h0);
        check("t5_itr", 32'(itr), 32'd0);
        irq = '0;
        step();

        // Reset mid-service discards pending and mask
        wr(NUIOOU - 1, 4'b1111);
        fire(4'b0001, 0);
        repeat (2) step();
        irq = 4'b0110;
        step();
        irq = '0;
        rd_stat("t6_stat", 32'h46);
        rst = 1'b1;
        step();
        check("t6_rst_itr", 32'(itr), 32'd0);
        check("t6_rst_id", 32'(itr_id), 32'd0);
        rd_stat("t6_rst_stat", 32'h0);
        rst = 1'b0;
        irq = 4'b0010;
        step();
        irq = '0;
        repeat (4) step();
        rd_stat("t6_pend_masked", 32'h02);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/itr_ctrl.md
Name: itr_ctrl

Overview:
Interrupt controller that sequences the single-bit `itr` input of the floating-point processor core.
It collects NSRC edge-triggered interrupt sources, applies a software-written enable mask, and selects the lowest-index pending source.
It issues a one-cycle `itr` pulse and then holds off further interrupts until the core signals end of service.
Mask writes and status reads go through the core's I/O port, at the top output and top input addresses.

Parameters:
- NSRC, 4: number of interrupt sources (2..16)
- NBDATA, 23: I/O word width (NBMANT+NBEXPO+1)
- NUIOIN, 8: number of core input addresses
- NUIOOU, 8: number of core output addresses
- MASK_ADDR, NUIOOU-1: output address of the mask register
- STAT_ADDR, NUIOIN-1: input address of the status word
- HOLDOFF, 2: idle cycles forced after end of service (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- irq  in  NSRC  interrupt request lines, already synchronous to clk
- out_en  in  1  core output strobe
- addr_out  in  $clog2(NUIOOU)  core output address
- data_out  in  NBDATA  core output word
- req_in  in  1  core input request
- addr_in  in  $clog2(NUIOIN)  core input address
- io_data  out  NBDATA  status word driven toward the core io_in mux
- itr  out  1  interrupt pulse to the core
- itr_id  out  $clog2(NSRC)  index of the source being serviced
- itr_end  in  1  one-cycle pulse from the core on return-from-interrupt

Behaviour:
- Clocking and reset: one clock; rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: mask=0, pend=0, itr=0, itr_id=0, hold counter=0, state=IDLE.
- During reset, irq_prev<=irq. A line already high at reset release does not create an edge.
- Edge detect: rise[i] = irq[i] & ~irq_prev[i]. A rise sets pend[i]. Rises are recorded in every state, including reset release +1.
- Mask write: when out_en && addr_out==MASK_ADDR, mask <= data_out[NSRC-1:0].
  - The word is taken as a raw bit pattern, with no float conversion.
  - The new mask takes effect the next cycle. Other addresses are ignored.
- Masked sources stay pending and are never cleared by masking.
- Status read is combinational.
  - When req_in && addr_in==STAT_ADDR: io_data = {zeros, busy, itr_id, pend}, where busy = (state!=IDLE).
  - Field order LSB first: pend[NSRC-1:0], itr_id, busy.
  - Otherwise io_data=0. Reads have no side effects.
- Selection: eligible = pend & mask. Priority goes to the lowest index.
- FSM:
  - IDLE: if eligible!=0, then itr_id<=winner, pend[winner]<=0 and itr<=1 on that edge, and go to ASSERT. Latency is rise -> itr high 2 cycles.
  - ASSERT: itr<=0 and go to SERVICE. itr is high for exactly one cycle.
  - SERVICE: wait for itr_end. On itr_end, load hold counter = HOLDOFF-1 and go to HOLD. itr_id stays stable through SERVICE.
  - HOLD: decrement the counter. At 0, go to IDLE.
- itr_end outside SERVICE is ignored.
- Set beats clear: if a new rise arrives on the winner in the same cycle it is cleared, pend[winner] stays 1.
- A rise on the source currently in service is recorded and serviced after HOLD (no nesting).
- A mask write to 0 during SERVICE does not abort service.
- rst mid-service returns to IDLE with itr=0 next edge and discards all pending.

Test Plan:
- Reset, then mask=4'b0101, pulse irq[2] -> itr high exactly 1 cycle, 2 cycles after the rise. itr_id=2. Status read shows busy=1, pend=0.
- irq[3] and irq[1] rise together with mask=4'b1111 -> source 1 is serviced first, pend=4'b1000. After itr_end plus 2 HOLD cycles, source 3 gets itr, itr_id=3.
- Mask=0, irq[0] rises -> no itr, status pend=4'b0001. Write mask=1 -> itr 2 cycles after the write.
- irq[2] rises again during SERVICE of source 2 -> no itr until HOLDOFF expires, then a second itr with itr_id=2.
- irq[1] held high through reset release -> no pending, no itr. itr_end while IDLE -> no state change.
- rst asserted in SERVICE with pend=4'b0110 -> next cycle itr=0, pend=0, mask=0, status busy=0.
